// File: rtl/redun_mont_unpack_pkg.sv
// Shared types, constants and helpers for the redundant-to-binary unpack block.
// The optional REDUN_UNPACK_OVF_CHK_EN build adds a range-check pass (see top).
package redun_mont_unpack_pkg;

  localparam int WRD_BITS          = 8;
  localparam int NUM_WRDS          = 4;
  localparam int BIN_BITS          = NUM_WRDS * WRD_BITS;
  localparam int UNPACK_CARRY_BITS = 2;
  localparam int RED_BITS          = BIN_BITS + UNPACK_CARRY_BITS;

  // Odd modulus; word i occupies bits [i*WRD_BITS +: WRD_BITS].
  localparam logic [BIN_BITS-1:0] P = 32'h9E37_79B9;

  // Redundant form: each word carries one overlap bit into the next word.
  typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;
  typedef logic [BIN_BITS-1:0]             bin_t;
  typedef logic [WRD_BITS-1:0]             wrd_t;

  // One-hot unpack sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_RESOLVE = 4'b0010,
    ST_SUB     = 4'b0100,
    ST_OUT     = 4'b1000
  } unpack_state_e;

  // WRD_BITS slice i of the modulus.
  function automatic wrd_t p_word(input int unsigned i);
    bin_t p;
    p = P;
    return p[i*WRD_BITS +: WRD_BITS];
  endfunction

  // Integer value of a redundant word vector (reference model helper).
  function automatic logic [RED_BITS-1:0] from_redun(input redun0_t r);
    logic [RED_BITS-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_WRDS; i++) begin
      acc = acc + (RED_BITS'(r[i]) << (i * WRD_BITS));
    end
    return acc;
  endfunction

endpackage

// File: rtl/redun_mont_unpack_if.sv
// Bus between the squaring-core result port and the unpack block, plus the
// binary result handshake towards the host. o_err exists only when
// REDUN_UNPACK_OVF_CHK_EN is defined.
//
// Handshake: i_val is a single-cycle capture pulse with no back-pressure (it is
// dropped unless the unpacker is idle). o_val/o_dat are held stable until the
// cycle where o_val && i_rdy, which is the transfer cycle.
interface redun_mont_unpack_if;
  import redun_mont_unpack_pkg::*;

  redun0_t i_mul;
  logic    i_val;
  logic    o_busy;
  bin_t    o_dat;
  logic    o_val;
  logic    i_rdy;
`ifdef REDUN_UNPACK_OVF_CHK_EN
  logic    o_err;

  modport slave  (input  i_mul, i_val, i_rdy, output o_busy, o_dat, o_val, o_err);
  modport master (output i_mul, i_val, i_rdy, input  o_busy, o_dat, o_val, o_err);
`else
  modport slave  (input  i_mul, i_val, i_rdy, output o_busy, o_dat, o_val);
  modport master (output i_mul, i_val, i_rdy, input  o_busy, o_dat, o_val);
`endif

endinterface

// File: rtl/redun_word_addsub.sv
// Single-word arithmetic step, evaluated within one cycle and registered by
// the caller. Add mode: a + cin with a 2-bit carry out (0..2).
// Subtract mode: a - b - cin with a 1-bit borrow out in cout_o[0].
module redun_word_addsub
  import redun_mont_unpack_pkg::*;
(
  input  logic              sub_i,
  input  logic [WRD_BITS:0] a_i,
  input  wrd_t              b_i,
  input  logic [1:0]        cin_i,
  output wrd_t              res_o,
  output logic [1:0]        cout_o
);

  logic [WRD_BITS+1:0] sum;
  logic [WRD_BITS+1:0] dif;

  // Both results are formed; mode selects which one leaves the block.
  always_comb begin
    sum = {1'b0, a_i} + {{WRD_BITS{1'b0}}, cin_i};
    dif = {1'b0, a_i} - {2'b00, b_i} - {{WRD_BITS{1'b0}}, cin_i};
    if (sub_i) begin
      res_o  = dif[WRD_BITS-1:0];
      cout_o = {1'b0, dif[WRD_BITS+1]};
    end else begin
      res_o  = sum[WRD_BITS-1:0];
      cout_o = sum[WRD_BITS+1:WRD_BITS];
    end
  end

endmodule

// File: rtl/redun_mont_unpack.sv
// Converts one redundant squaring result to canonical binary in [0, P).
// Word-serial: NUM_WRDS cycles of carry resolution, then MAX_SUB fixed passes
// of conditional subtract-P, so latency never depends on the data.
// REDUN_UNPACK_OVF_CHK_EN adds one compare-only pass driving o_err.
module redun_mont_unpack
  import redun_mont_unpack_pkg::*;
#(
  parameter int MAX_SUB = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  redun_mont_unpack_if.slave   bus,
  output unpack_state_e        dbg_state_o
);

`ifdef REDUN_UNPACK_OVF_CHK_EN
  localparam int CHK_PASSES = 1;
`else
  localparam int CHK_PASSES = 0;
`endif
  localparam int PASSES = MAX_SUB + CHK_PASSES;
  localparam int PASS_W = $clog2(PASSES + 1);
  localparam int CNT_W  = $clog2(NUM_WRDS + 1);
  localparam logic [CNT_W-1:0]  LAST_WRD  = CNT_W'(NUM_WRDS - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);
  localparam logic [PASS_W-1:0] CHK_PASS  = PASS_W'(MAX_SUB);

  unpack_state_e        state_q;
  logic [WRD_BITS:0]    buf_q [NUM_WRDS];      // word 0 at the head
  wrd_t                 sh_q  [NUM_WRDS-1];    // trial difference, low words
  logic [1:0]           carry_q;               // carry in RESOLVE, borrow in SUB
  logic [1:0]           ovf_q;                 // value bits above the top word
  logic [CNT_W-1:0]     wrd_cnt_q;
  logic [PASS_W-1:0]    pass_q;
  logic                 o_val_q;
`ifdef REDUN_UNPACK_OVF_CHK_EN
  logic                 err_q;
`endif

  logic                 au_sub_d;
  logic [WRD_BITS:0]    au_a_d;
  wrd_t                 au_b_d;
  logic [1:0]           au_cin_d;
  wrd_t                 au_res;
  logic [1:0]           au_cout;
  logic                 last_wrd_d;
  logic                 commit_d;
  logic [1:0]           ovf_d;
  bin_t                 dat_d;

  redun_word_addsub u_addsub (
    .sub_i  (au_sub_d),
    .a_i    (au_a_d),
    .b_i    (au_b_d),
    .cin_i  (au_cin_d),
    .res_o  (au_res),
    .cout_o (au_cout)
  );

  // Operand selection for the shared word unit and end-of-pass decision.
  // A pass commits only when the top register absorbs the final borrow; the
  // compare-only pass never commits.
  always_comb begin
    au_sub_d = (state_q == ST_SUB);
    au_a_d   = buf_q[0];
    au_b_d   = '0;
    au_cin_d = carry_q;
    if (au_sub_d) begin
      au_a_d   = {1'b0, buf_q[0][WRD_BITS-1:0]};
      au_b_d   = p_word(32'(wrd_cnt_q));
      au_cin_d = {1'b0, carry_q[0]};
    end
    last_wrd_d = (wrd_cnt_q == LAST_WRD);
    ovf_d      = ovf_q - {1'b0, au_cout[0]};
    commit_d   = !((ovf_q == 2'd0) && au_cout[0]) && (pass_q != CHK_PASS);
  end

  // Flatten the low WRD_BITS of each buffered word into the binary result.
  always_comb begin
    dat_d = '0;
    for (int i = 0; i < NUM_WRDS; i++) begin
      dat_d[i*WRD_BITS +: WRD_BITS] = buf_q[i][WRD_BITS-1:0];
    end
  end

  assign bus.o_dat   = dat_d;
  assign bus.o_val   = o_val_q;
  assign bus.o_busy  = (state_q != ST_IDLE);
`ifdef REDUN_UNPACK_OVF_CHK_EN
  assign bus.o_err   = err_q;
`endif
  assign dbg_state_o = state_q;

  // Sequencer: capture, resolve carries, fixed subtract passes, hold result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      for (int i = 0; i < NUM_WRDS; i++) buf_q[i] <= '0;
      for (int i = 0; i < NUM_WRDS-1; i++) sh_q[i] <= '0;
      carry_q   <= '0;
      ovf_q     <= '0;
      wrd_cnt_q <= '0;
      pass_q    <= '0;
      o_val_q   <= 1'b0;
`ifdef REDUN_UNPACK_OVF_CHK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.i_val) begin
            for (int i = 0; i < NUM_WRDS; i++) buf_q[i] <= bus.i_mul[i];
            carry_q   <= '0;
            wrd_cnt_q <= '0;
            state_q   <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          for (int i = 0; i < NUM_WRDS-1; i++) buf_q[i] <= buf_q[i+1];
          buf_q[NUM_WRDS-1] <= {1'b0, au_res};
          if (last_wrd_d) begin
            ovf_q     <= au_cout;
            carry_q   <= '0;
            wrd_cnt_q <= '0;
            pass_q    <= '0;
            state_q   <= ST_SUB;
          end else begin
            carry_q   <= au_cout;
            wrd_cnt_q <= wrd_cnt_q + 1'b1;
          end
        end
        ST_SUB: begin
          // Buffer rotates so it is back in order after NUM_WRDS cycles.
          for (int i = 0; i < NUM_WRDS-1; i++) buf_q[i] <= buf_q[i+1];
          buf_q[NUM_WRDS-1] <= buf_q[0];
          for (int i = 0; i < NUM_WRDS-2; i++) sh_q[i] <= sh_q[i+1];
          sh_q[NUM_WRDS-2] <= au_res;
          if (last_wrd_d) begin
            carry_q   <= '0;
            wrd_cnt_q <= '0;
            if (commit_d) begin
              for (int i = 0; i < NUM_WRDS-1; i++) buf_q[i] <= {1'b0, sh_q[i]};
              buf_q[NUM_WRDS-1] <= {1'b0, au_res};
              ovf_q <= ovf_d;
            end
`ifdef REDUN_UNPACK_OVF_CHK_EN
            if (pass_q == CHK_PASS) err_q <= (ovf_q != 2'd0) || !au_cout[0];
`endif
            if (pass_q == LAST_PASS) begin
              o_val_q <= 1'b1;
              state_q <= ST_OUT;
            end else begin
              pass_q  <= pass_q + 1'b1;
            end
          end else begin
            carry_q   <= au_cout;
            wrd_cnt_q <= wrd_cnt_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (o_val_q && bus.i_rdy) begin
            o_val_q <= 1'b0;
`ifdef REDUN_UNPACK_OVF_CHK_EN
            err_q   <= 1'b0;
`endif
            state_q <= ST_IDLE;
          end
        end
        default: begin
          o_val_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
